// File: rtl/mem_preload_dump_ctrl.sv
// Load/run/dump sequencer: preloads N memory channels, runs the core until a TOHOST store,
// then streams a window of one channel out. Optional run watchdog: MEM_PRELOAD_WATCHDOG_EN.
module mem_preload_dump_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 14,
    parameter int          NUM_CH      = 2,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int          DUMP_CH     = 1,
    parameter int          DUMP_BASE   = 0,
    parameter int          DUMP_WORDS  = 256,
    parameter int          WDOG_CYCLES = 100000,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [CH_W-1:0]          ld_ch,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     ld_last,
    output logic [NUM_CH-1:0]        mem_we,
    output logic [NUM_CH-1:0]        mem_re,
    output logic [NUM_CH*ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [NUM_CH*DATA_W-1:0] mem_rdata,
    output logic                     core_rst,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data,
    output logic                     done,
    output logic                     pass,
    output logic [DATA_W-1:0]        fail_code,
    output logic                     load_err,
    output logic                     timeout
);

    localparam int CNT_W = $clog2(DUMP_WORDS + 2);
    localparam logic [CNT_W-1:0] NWORDS   = CNT_W'(DUMP_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((DUMP_WORDS > 0) ? DUMP_WORDS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                load_err_q, load_err_d;
    logic                pass_q, pass_d;
    logic [DATA_W-1:0]   fail_code_q, fail_code_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                dump_valid_q, dump_valid_d;
    logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0]   dump_data_q, dump_data_d;

    logic                ld_fire;
    logic                tohost_hit;
    logic                dump_accept;
    logic                rd_issue;
    logic                run_end;
    logic [ADDR_W-1:0]   issue_addr;

`ifdef MEM_PRELOAD_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic                timeout_q, timeout_d;
    logic [31:0]         wdog_cnt_q, wdog_cnt_d;
`else
    logic [31:0]         unused_wdog;
    assign unused_wdog = 32'(WDOG_CYCLES);
`endif

    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

    assign ld_fire     = ld_valid && (state_q == S_LOAD);
    assign tohost_hit  = st_valid && (st_addr == TOHOST_ADDR);
    assign dump_accept = dump_valid_q && dump_ready;
    assign issue_addr  = ADDR_W'(DUMP_BASE + 32'(rd_cnt_q));

    // Read issue waits for the previous word to clear the output register, which caps
    // the dump at one word every two cycles.
    assign rd_issue = (state_q == S_DUMP) && !pend_q && (!dump_valid_q || dump_ready)
                      && (rd_cnt_q != NWORDS);

    always_comb begin
        state_d      = state_q;
        load_err_d   = load_err_q;
        pass_d       = pass_q;
        fail_code_d  = fail_code_q;
        rd_cnt_d     = rd_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        dump_valid_d = dump_valid_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        run_end      = 1'b0;
`ifdef MEM_PRELOAD_WATCHDOG_EN
        timeout_d    = timeout_q;
        wdog_cnt_d   = wdog_cnt_q;
`endif
        ld_ready  = 1'b0;
        mem_we    = '0;
        mem_re    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        core_rst  = 1'b1;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_fire) begin
                    if (32'(ld_ch) < NUM_CH) begin
                        mem_wdata = ld_data;
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (ld_ch == CH_W'(c)) begin
                                mem_we[c]                    = 1'b1;
                                mem_addr[c*ADDR_W +: ADDR_W] = ld_addr;
                            end
                        end
                    end else begin
                        load_err_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = S_RUN;
`ifdef MEM_PRELOAD_WATCHDOG_EN
                        wdog_cnt_d = '0;
`endif
                    end
                end
            end

            S_RUN: begin
                core_rst = 1'b0;
                // A tohost store takes priority over a watchdog expiry in the same cycle.
                if (tohost_hit) begin
                    pass_d      = (st_data == DATA_W'(1));
                    fail_code_d = st_data >> 1;
                    run_end     = 1'b1;
                end
`ifdef MEM_PRELOAD_WATCHDOG_EN
                else if (wdog_cnt_q == WDOG_LAST) begin
                    timeout_d   = 1'b1;
                    pass_d      = 1'b0;
                    fail_code_d = '1;
                    run_end     = 1'b1;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 32'd1;
                end
`endif
                if (run_end) begin
                    state_d      = (DUMP_WORDS == 0) ? S_DONE : S_DUMP;
                    rd_cnt_d     = '0;
                    acc_cnt_d    = '0;
                    pend_d       = 1'b0;
                    dump_valid_d = 1'b0;
                end
            end

            S_DUMP: begin
                // Memory returns data the cycle after the read; it is registered here so
                // the word is presented two cycles after issue.
                if (pend_q) begin
                    dump_valid_d = 1'b1;
                    dump_data_d  = mem_rdata[DUMP_CH*DATA_W +: DATA_W];
                    dump_addr_d  = pend_addr_q;
                    pend_d       = 1'b0;
                end else if (dump_accept) begin
                    dump_valid_d = 1'b0;
                end
                if (rd_issue) begin
                    mem_re[DUMP_CH]                    = 1'b1;
                    mem_addr[DUMP_CH*ADDR_W +: ADDR_W] = issue_addr;
                    pend_d                             = 1'b1;
                    pend_addr_d                        = issue_addr;
                    rd_cnt_d                           = rd_cnt_q + CNT_W'(1);
                end
                if (dump_accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == LAST_CNT) begin
                        state_d      = S_DONE;
                        dump_valid_d = 1'b0;
                    end
                end
            end

            S_DONE: begin
                done = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            load_err_q   <= 1'b0;
            pass_q       <= 1'b0;
            fail_code_q  <= '0;
            rd_cnt_q     <= '0;
            acc_cnt_q    <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
`ifdef MEM_PRELOAD_WATCHDOG_EN
            timeout_q    <= 1'b0;
            wdog_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            load_err_q   <= load_err_d;
            pass_q       <= pass_d;
            fail_code_q  <= fail_code_d;
            rd_cnt_q     <= rd_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
`ifdef MEM_PRELOAD_WATCHDOG_EN
            timeout_q    <= timeout_d;
            wdog_cnt_q   <= wdog_cnt_d;
`endif
        end
    end

    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
    assign pass       = pass_q;
    assign fail_code  = fail_code_q;
    assign load_err   = load_err_q;
`ifdef MEM_PRELOAD_WATCHDOG_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule
